// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Shared core definitions: the commit-bus type encoding and the default
//   widths used by the commit/retire path, following the standard core
//   configuration.
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int CORE_MAX_COMMITS = 2;
    localparam int CORE_ARCH_W      = 5;
    localparam int CORE_PHY_W       = 7;
    localparam int CORE_TAG_W       = 5;
    localparam int CORE_VAL_W       = 32;

    typedef enum logic [1:0] {
        COMMIT_NOP    = 2'd0,
        COMMIT_REG    = 2'd1,
        COMMIT_STORE  = 2'd2,
        COMMIT_BRANCH = 2'd3
    } commit_type_t;

endpackage

// File: rtl/commit_retire_sink_free_ret_fifo.sv
// ---------------------------------------------------------------------------
// free_ret_fifo
//   Return queue for superseded physical registers. Accepts up to LANES
//   pushes per cycle (push_data[0..push_cnt-1], in that order) and one pop
//   per cycle. Pushes that do not fit are dropped; a pop in the same cycle
//   frees one slot for the pushes, so push+pop is legal when full.
// Ports
//   clk, reset_n    clock, synchronous active-low reset
//   push_cnt        number of valid entries in push_data this cycle
//   push_data       entries to push, lane order
//   pop             remove head this cycle (caller guarantees count != 0)
//   count           registered occupancy
//   head            registered entry at the read pointer
// ---------------------------------------------------------------------------
module free_ret_fifo #(
    parameter int LANES = 2,
    parameter int WIDTH = 7,
    parameter int DEPTH = 8,
    localparam int PCNT_W = $clog2(LANES + 1),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [PCNT_W-1:0]           push_cnt,
    input  logic [LANES-1:0][WIDTH-1:0] push_data,
    input  logic                        pop,
    output logic [CNT_W-1:0]            count,
    output logic [WIDTH-1:0]            head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    int               space;
    int               n_acc;

    // Slots usable this cycle include the one released by a concurrent pop.
    always_comb begin
        space = DEPTH - int'(count) + int'(pop);
        n_acc = (int'(push_cnt) < space) ? int'(push_cnt) : space;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_acc);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + CNT_W'(n_acc) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i < n_acc) mem[wr_ptr + PTR_W'(i)] <= push_data[i];
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/commit_retire_sink.sv
// ---------------------------------------------------------------------------
// commit_retire_sink
//   Receiving end of the ROB commit bus. Maintains the retirement RAT
//   (arch reg -> committed phys reg), returns superseded phys regs to the
//   rename free list through free_ret_fifo, checks the program-order tag
//   sequence and counts retired instructions.
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   commit_*              per-lane commit bus; lane 0 is the oldest
//   commit_stall          ROB must not commit this cycle (FIFO nearly full)
//   free_valid/ready/phy_addr  free-list return handshake
//   rrat_rd_addr/phy      combinational RRAT read, sees commits from next cycle
//   retired_cnt           64-bit retired instruction count
//   order_err, ovf_err    sticky tag-sequence and overflow errors
//   arch_rd_value         committed value at rrat_rd_addr (COMMIT_ARCH_VALUE_EN)
// Build option
//   COMMIT_ARCH_VALUE_EN  adds the architectural value file and arch_rd_value.
// ---------------------------------------------------------------------------
module commit_retire_sink
    import core_pkg::*;
#(
    parameter int MAX_COMMITS = CORE_MAX_COMMITS,
    parameter int ARCH_W      = CORE_ARCH_W,
    parameter int PHY_W       = CORE_PHY_W,
    parameter int TAG_W       = CORE_TAG_W,
    parameter int VAL_W       = CORE_VAL_W,
    parameter int FREE_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [MAX_COMMITS-1:0]            commit_valid,
    input  logic [MAX_COMMITS-1:0][TAG_W-1:0] commit_tag,
    input  logic [MAX_COMMITS-1:0][ARCH_W-1:0] commit_arch_reg_addr,
    input  logic [MAX_COMMITS-1:0][PHY_W-1:0] commit_phy_reg_addr,
    input  logic [MAX_COMMITS-1:0][VAL_W-1:0] commit_value,
    input  commit_type_t [MAX_COMMITS-1:0]    commit_type,
    output logic                              commit_stall,
    output logic                              free_valid,
    input  logic                              free_ready,
    output logic [PHY_W-1:0]                  free_phy_addr,
    input  logic [ARCH_W-1:0]                 rrat_rd_addr,
    output logic [PHY_W-1:0]                  rrat_rd_phy,
    output logic [63:0]                       retired_cnt,
    output logic                              order_err,
    output logic                              ovf_err
`ifdef COMMIT_ARCH_VALUE_EN
    ,
    output logic [VAL_W-1:0]                  arch_rd_value
`endif
);
    localparam int NREGS  = 2 ** ARCH_W;
    localparam int PCNT_W = $clog2(MAX_COMMITS + 1);
    localparam int CNT_W  = $clog2(FREE_DEPTH + 1);

    logic [PHY_W-1:0]                  rrat [NREGS];
    logic [TAG_W-1:0]                  expected_tag;
    logic [MAX_COMMITS-1:0]            lane_wr;
    logic [MAX_COMMITS-1:0][PHY_W-1:0] lane_old;
    logic [MAX_COMMITS-1:0][PHY_W-1:0] push_data;
    logic [PCNT_W-1:0]                 push_cnt;
    logic [PCNT_W-1:0]                 n_valid;
    logic [CNT_W-1:0]                  fifo_count;
    logic                              pop;
    logic                              tag_bad;
    int                                slot;

    always_comb begin
        for (int k = 0; k < MAX_COMMITS; k++) begin
            lane_wr[k] = commit_valid[k] && (commit_type[k] == COMMIT_REG)
                         && (commit_arch_reg_addr[k] != '0);
        end
    end

    // Superseded mapping per lane. A younger lane writing the same arch reg
    // as an older lane in the same cycle supersedes the older lane's phys
    // reg, not the RRAT entry. Freed regs are packed in lane order.
    always_comb begin
        slot      = 0;
        lane_old  = '0;
        push_data = '0;
        for (int k = 0; k < MAX_COMMITS; k++) begin
            lane_old[k] = rrat[commit_arch_reg_addr[k]];
            for (int j = 0; j < k; j++) begin
                if (lane_wr[j] && commit_arch_reg_addr[j] == commit_arch_reg_addr[k])
                    lane_old[k] = commit_phy_reg_addr[j];
            end
            if (lane_wr[k]) begin
                for (int s = 0; s < MAX_COMMITS; s++) begin
                    if (s == slot) push_data[s] = lane_old[k];
                end
                slot = slot + 1;
            end
        end
        push_cnt = PCNT_W'(slot);
    end

    // Lane k must carry expected_tag+k; a valid lane above an invalid one
    // breaks the contiguity rule.
    always_comb begin
        tag_bad = 1'b0;
        for (int k = 0; k < MAX_COMMITS; k++) begin
            if (commit_valid[k] && commit_tag[k] != expected_tag + TAG_W'(k))
                tag_bad = 1'b1;
        end
        for (int k = 1; k < MAX_COMMITS; k++) begin
            if (!commit_valid[k-1] && commit_valid[k]) tag_bad = 1'b1;
        end
    end

    assign n_valid      = PCNT_W'($countones(commit_valid));
    assign free_valid   = (fifo_count != '0);
    assign pop          = free_valid && free_ready;
    assign commit_stall = (FREE_DEPTH - int'(fifo_count)) < MAX_COMMITS;
    assign rrat_rd_phy  = rrat[rrat_rd_addr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) rrat[i] <= PHY_W'(i);
            expected_tag <= '0;
            retired_cnt  <= '0;
            order_err    <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            // Later lanes override earlier ones, leaving the youngest mapping.
            for (int k = 0; k < MAX_COMMITS; k++) begin
                if (lane_wr[k]) rrat[commit_arch_reg_addr[k]] <= commit_phy_reg_addr[k];
            end
            expected_tag <= expected_tag + TAG_W'(n_valid);
            retired_cnt  <= retired_cnt + 64'(n_valid);
            if (tag_bad) order_err <= 1'b1;
            if (commit_stall && |commit_valid) ovf_err <= 1'b1;
        end
    end

    free_ret_fifo #(
        .LANES (MAX_COMMITS),
        .WIDTH (PHY_W),
        .DEPTH (FREE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (free_phy_addr)
    );

`ifdef COMMIT_ARCH_VALUE_EN
    logic [VAL_W-1:0] arf [NREGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) arf[i] <= '0;
        end else begin
            for (int k = 0; k < MAX_COMMITS; k++) begin
                if (lane_wr[k]) arf[commit_arch_reg_addr[k]] <= commit_value[k];
            end
        end
    end

    // Register 0 reads as zero regardless of storage contents.
    assign arch_rd_value = (rrat_rd_addr == '0) ? '0 : arf[rrat_rd_addr];
`else
    logic value_unused;
    assign value_unused = ^commit_value;
`endif

endmodule

// File: tb/tb_commit_retire_sink.sv
module tb_commit_retire_sink;
    import core_pkg::*;

    localparam int MC = 2;
    localparam int AW = 5;
    localparam int PW = 7;
    localparam int TW = 5;
    localparam int VW = 32;
    localparam int FD = 8;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [MC-1:0]            commit_valid;
    logic [MC-1:0][TW-1:0]    commit_tag;
    logic [MC-1:0][AW-1:0]    commit_arch_reg_addr;
    logic [MC-1:0][PW-1:0]    commit_phy_reg_addr;
    logic [MC-1:0][VW-1:0]    commit_value;
    commit_type_t [MC-1:0]    commit_type;
    logic                     commit_stall;
    logic                     free_valid;
    logic                     free_ready;
    logic [PW-1:0]            free_phy_addr;
    logic [AW-1:0]            rrat_rd_addr;
    logic [PW-1:0]            rrat_rd_phy;
    logic [63:0]              retired_cnt;
    logic                     order_err;
    logic                     ovf_err;
`ifdef COMMIT_ARCH_VALUE_EN
    logic [VW-1:0]            arch_rd_value;
`endif

    commit_retire_sink #(
        .MAX_COMMITS (MC), .ARCH_W (AW), .PHY_W (PW),
        .TAG_W (TW), .VAL_W (VW), .FREE_DEPTH (FD)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .commit_valid         (commit_valid),
        .commit_tag           (commit_tag),
        .commit_arch_reg_addr (commit_arch_reg_addr),
        .commit_phy_reg_addr  (commit_phy_reg_addr),
        .commit_value         (commit_value),
        .commit_type          (commit_type),
        .commit_stall         (commit_stall),
        .free_valid           (free_valid),
        .free_ready           (free_ready),
        .free_phy_addr        (free_phy_addr),
        .rrat_rd_addr         (rrat_rd_addr),
        .rrat_rd_phy          (rrat_rd_phy),
        .retired_cnt          (retired_cnt),
        .order_err            (order_err),
        .ovf_err              (ovf_err)
`ifdef COMMIT_ARCH_VALUE_EN
        ,
        .arch_rd_value        (arch_rd_value)
`endif
    );

    always #5 clk = ~clk;

    // Reference state
    logic [PW-1:0] mrrat [32];
    logic [PW-1:0] fq [$];
    logic [TW-1:0] mtag;
    int            n_cmp = 0;
    int            n_err = 0;

    typedef struct {
        logic [1:0]   v;
        logic [TW-1:0] t0, t1;
        logic [AW-1:0] a0, a1;
        logic [PW-1:0] p0, p1;
        commit_type_t c0, c1;
        logic [AW-1:0] rd;
        logic [PW-1:0] exp_rd;
        logic [63:0]   exp_ret;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                         input commit_type_t c0, input commit_type_t c1);
        commit_valid            = v;
        commit_tag[0]           = t0;
        commit_tag[1]           = t1;
        commit_arch_reg_addr[0] = a0;
        commit_arch_reg_addr[1] = a1;
        commit_phy_reg_addr[0]  = p0;
        commit_phy_reg_addr[1]  = p1;
        commit_value[0]         = {25'h0, p0};
        commit_value[1]         = {25'h1, p1};
        commit_type[0]          = c0;
        commit_type[1]          = c1;
    endtask

    // One clock: check stall/free handshake mid-cycle, advance the reference
    // with the commit being presented, then cross the edge.
    task automatic tick();
        logic          exp_stall;
        logic [AW-1:0] a;
        logic          upd;
        #2;
        exp_stall = ((FD - fq.size()) < MC);
        chk("commit_stall", commit_stall, exp_stall);
        chk("free_valid", free_valid, fq.size() != 0);
        if (free_valid === 1'b1 && free_ready === 1'b1 && fq.size() != 0)
            chk("free_phy_addr", free_phy_addr, fq.pop_front());
        for (int k = 0; k < MC; k++) begin
            a   = commit_arch_reg_addr[k];
            upd = commit_valid[k] && commit_type[k] == COMMIT_REG && a != 0;
            if (upd) begin
                if (fq.size() < FD) fq.push_back(mrrat[a]);
                mrrat[a] = commit_phy_reg_addr[k];
            end
            if (commit_valid[k]) mtag = mtag + TW'(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, '0, '0, '0, '0, '0, '0, COMMIT_NOP, COMMIT_NOP);
        tick();
    endtask

    task automatic c2(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                      input commit_type_t c0, input commit_type_t c1);
        drive(v, mtag, mtag + TW'(1), a0, a1, p0, p1, c0, c1);
        tick();
    endtask

    task automatic model_reset();
        fq.delete();
        for (int i = 0; i < 32; i++) mrrat[i] = PW'(i);
        mtag = '0;
    endtask

    task automatic drain(input string name);
        free_ready = 1'b1;
        for (int i = 0; i < 24 && fq.size() != 0; i++) idle();
        idle();
        chk(name, free_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 5'd0, 5'd0, 5'd5,  5'd0,  7'd40, 7'd0,  COMMIT_REG,    COMMIT_NOP,   5'd5,  7'd40, 64'd1};
        tbl[1] = '{2'b11, 5'd1, 5'd2, 5'd3,  5'd3,  7'd50, 7'd51, COMMIT_REG,    COMMIT_REG,   5'd3,  7'd51, 64'd3};
        tbl[2] = '{2'b11, 5'd3, 5'd4, 5'd0,  5'd7,  7'd60, 7'd61, COMMIT_REG,    COMMIT_STORE, 5'd7,  7'd7,  64'd5};
        tbl[3] = '{2'b11, 5'd5, 5'd6, 5'd9,  5'd9,  7'd65, 7'd70, COMMIT_BRANCH, COMMIT_REG,   5'd9,  7'd70, 64'd7};
        tbl[4] = '{2'b01, 5'd7, 5'd0, 5'd5,  5'd0,  7'd41, 7'd0,  COMMIT_REG,    COMMIT_NOP,   5'd5,  7'd41, 64'd8};
        tbl[5] = '{2'b11, 5'd8, 5'd9, 5'd12, 5'd31, 7'd0,  7'd99, COMMIT_NOP,    COMMIT_REG,   5'd31, 7'd99, 64'd10};

        // Reset
        reset_n      = 1'b0;
        free_ready   = 1'b1;
        rrat_rd_addr = 5'd5;
        drive(2'b00, '0, '0, '0, '0, '0, '0, COMMIT_NOP, COMMIT_NOP);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("reset_rrat5", rrat_rd_phy, 7'd5);
        chk("reset_free_valid", free_valid, 1'b0);
        chk("reset_stall", commit_stall, 1'b0);
        chk("reset_retired", retired_cnt, 64'd0);
        chk("reset_order_err", order_err, 1'b0);
        chk("reset_ovf_err", ovf_err, 1'b0);

        // Table vectors: single/dual lanes, same-arch pair, arch0/STORE, BRANCH
        for (int i = 0; i < 6; i++) begin
            rrat_rd_addr = tbl[i].rd;
            drive(tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].a0, tbl[i].a1,
                  tbl[i].p0, tbl[i].p1, tbl[i].c0, tbl[i].c1);
            #1;
            chk($sformatf("no_bypass_%0d", i), rrat_rd_phy, mrrat[tbl[i].rd]);
            tick();
            chk($sformatf("rrat_%0d", i), rrat_rd_phy, tbl[i].exp_rd);
            chk($sformatf("retired_%0d", i), retired_cnt, tbl[i].exp_ret);
            chk($sformatf("order_ok_%0d", i), order_err, 1'b0);
        end
        rrat_rd_addr = 5'd0;
        #1;
        chk("rrat_arch0", rrat_rd_phy, 7'd0);
        drain("drain_table");

        // Backpressure: fill FIFO, then commit while stalled
        free_ready = 1'b0;
        c2(2'b11, 5'd1, 5'd2, 7'd80, 7'd81, COMMIT_REG, COMMIT_REG);
        c2(2'b11, 5'd1, 5'd2, 7'd82, 7'd83, COMMIT_REG, COMMIT_REG);
        c2(2'b11, 5'd1, 5'd2, 7'd84, 7'd85, COMMIT_REG, COMMIT_REG);
        chk("stall_at_6", commit_stall, 1'b0);
        c2(2'b11, 5'd1, 5'd2, 7'd86, 7'd87, COMMIT_REG, COMMIT_REG);
        chk("stall_at_8", commit_stall, 1'b1);
        chk("ovf_before", ovf_err, 1'b0);
        c2(2'b11, 5'd1, 5'd2, 7'd88, 7'd89, COMMIT_REG, COMMIT_REG);
        chk("ovf_set", ovf_err, 1'b1);
        rrat_rd_addr = 5'd2;
        #1;
        chk("rrat_upd_in_ovf", rrat_rd_phy, 7'd89);
        drain("drain_full");
        chk("ovf_sticky", ovf_err, 1'b1);

        // Tag wrap then tag break
        for (int i = 0; i < 40 && mtag != 5'd31; i++) begin
            if (mtag == 5'd30) c2(2'b01, 5'd0, 5'd0, 7'd0, 7'd0, COMMIT_NOP, COMMIT_NOP);
            else               c2(2'b11, 5'd0, 5'd0, 7'd0, 7'd0, COMMIT_NOP, COMMIT_NOP);
        end
        drive(2'b11, 5'd31, 5'd0, 5'd0, 5'd0, 7'd0, 7'd0, COMMIT_NOP, COMMIT_NOP);
        tick();
        chk("tag_wrap_ok", order_err, 1'b0);
        drive(2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 7'd0, 7'd0, COMMIT_NOP, COMMIT_NOP);
        tick();
        chk("tag_break", order_err, 1'b1);
        idle();
        chk("order_sticky", order_err, 1'b1);

        // Reset with FIFO contents in flight
        free_ready = 1'b0;
        c2(2'b11, 5'd4, 5'd6, 7'd90, 7'd91, COMMIT_REG, COMMIT_REG);
        drive(2'b00, '0, '0, '0, '0, '0, '0, COMMIT_NOP, COMMIT_NOP);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        rrat_rd_addr = 5'd4;
        #1;
        chk("mid_reset_free_valid", free_valid, 1'b0);
        chk("mid_reset_stall", commit_stall, 1'b0);
        chk("mid_reset_retired", retired_cnt, 64'd0);
        chk("mid_reset_order", order_err, 1'b0);
        chk("mid_reset_ovf", ovf_err, 1'b0);
        chk("mid_reset_rrat4", rrat_rd_phy, 7'd4);

        // Lane gap: lane 1 valid with lane 0 idle
        rrat_rd_addr = 5'd8;
        drive(2'b10, 5'd0, 5'd1, 5'd0, 5'd8, 7'd0, 7'd100, COMMIT_NOP, COMMIT_REG);
        tick();
        chk("gap_order_err", order_err, 1'b1);
        chk("gap_retired", retired_cnt, 64'd1);
        chk("gap_rrat8", rrat_rd_phy, 7'd100);
        drain("drain_gap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
